pwm_sample_decoder: RTL and testbench
=====================================

// Module: pwm_sample_decoder
// PURPOSE
//   Recovers audio sample values from a PWM audio stream by measuring the high time of each PWM period.
//   Used as the receive end of the PWM audio output: bench/FPGA loopback of the music generator's pwm pin.
//   Sits beside the audio generator in the PLL clock domain.
//   Reports one sample per period, plus lock and period-error status.
// PARAMETERS
//   WIDTH        8   sample width; nominal PWM period is 2**WIDTH clocks
//   SYNC_STAGES  2   synchroniser flops on pwm_in (>=2)
// PORTS
//   clk           in   1          system clock (PLL output)
//   rst           in   1          synchronous reset, active-high
//   pwm_in        in   1          PWM audio stream, asynchronous to clk
//   sample        out  WIDTH      last decoded sample (high-cycle count, clamped)
//   sample_valid  out  1          one-cycle strobe: sample/period/period_err updated
//   period        out  WIDTH+2    measured period in clocks of the last emitted sample (saturating)
//   period_err    out  1          valid with sample_valid: period != 2**WIDTH
//   locked        out  1          1 while full periods are being measured
// BEHAVIOUR
//   - Reset: all outputs 0, sync chain 0, counters 0, state ACQUIRE; applies on the clock edge where rst=1.
//   - pwm_in passes through SYNC_STAGES flops -> s.
//   - One further flop holds s_d; rise = s & ~s_d.
//   - Counters per period, WIDTH+2 bits, saturating at all-ones:
//       - cnt_p: cycles since last rise.
//       - cnt_h: cycles with s=1 since last rise.
//       - Both restart at 1/1 on the rise cycle.
//   - States:
//       - ACQUIRE: wait for rise -> HIGH. No sample emitted; partial period discarded.
//       - HIGH: s=1. On fall -> LOW. On rise (1-cycle low glitch absorbed by sync) -> emit, stay HIGH.
//       - LOW: s=0. On rise -> emit, go HIGH.
//       - STUCK: entered from any state when cnt_p reaches 2**(WIDTH+1) with no rise.
//   - Emit (registered, visible cycle after rise):
//       - sample = min(cnt_h, 2**WIDTH-1)
//       - period = cnt_p
//       - period_err = (cnt_p != 2**WIDTH)
//       - sample_valid = 1 for one cycle; counters restart on that rise.
//   - Latency: pwm_in rising edge -> sample_valid = SYNC_STAGES+2 clk edges.
//   - STUCK handling:
//       - On entry, and every 2**WIDTH cycles thereafter: sample = s ? 2**WIDTH-1 : 0, period = 2**WIDTH, period_err = 0, sample_valid = 1.
//       - On rise -> HIGH, counters restart, no emit for that partial period.
//   - locked:
//       - Set on the first emit from a rise while in HIGH/LOW.
//       - Cleared in ACQUIRE, in STUCK, and on reset.
//   - Counter saturation: never wraps; saturated cnt_p reports period = all-ones, period_err = 1.
//   - Between emits: sample/period/period_err hold; sample_valid is never asserted two consecutive cycles.
//   - Reset mid-period: the in-progress measurement is discarded; the next sample comes only after a fresh ACQUIRE.
// TESTING
//   1. Period 256, high 100, steady:
//      - first full period after reset -> sample=100, period=256, period_err=0, locked=1.
//      - then a valid strobe every 256 clk.
//   2. Duty extremes, period 256:
//      - high 255/low 1 -> sample=255.
//      - high 1/low 255 -> sample=1.
//      - no missed strobes.
//   3. pwm_in held low 1000 clk after lock:
//      - sample=0 valid 512 clk after last rise, then every 256 clk.
//      - locked=0.
//      - repeat held high -> sample=255.
//   4. Period 300, high 150 -> sample=150, period=300, period_err=1. Period 200, high 50 -> sample=50, period_err=1.
//   5. rst pulsed 1 cycle mid-HIGH:
//      - next cycle all outputs 0.
//      - no sample_valid until one complete period after the following rise.
//   6. Latency: single rise on pwm_in at clk edge k -> sample_valid at edge k+SYNC_STAGES+2 (check SYNC_STAGES=2 and 3).

Source files
------------

// File: rtl/pwm_sample_decoder.sv
// Recovers PWM audio samples by counting the high time of each PWM period.
// Emits one sample per period, plus lock and period-error status.
module pwm_sample_decoder #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_pwm_in,
  output logic [WIDTH-1:0] o_sample,
  output logic             o_sample_valid,
  output logic [WIDTH+1:0] o_period,
  output logic             o_period_err,
  output logic             o_locked
);

  localparam int CW = WIDTH + 2;
  localparam logic [CW-1:0] C_NOMINAL = CW'(1 << WIDTH);
  localparam logic [CW-1:0] C_STUCK   = CW'(1 << (WIDTH + 1));
  localparam logic [CW-1:0] C_SMAX    = CW'((1 << WIDTH) - 1);

  typedef enum logic [1:0] {
    ST_ACQUIRE,
    ST_HIGH,
    ST_LOW,
    ST_STUCK
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [SYNC_STAGES-1:0] r_sync;
  logic [SYNC_STAGES:0]   r_vld;
  logic                   r_s_d;
  logic                   r_rise;
  logic                   r_fall;
  logic [CW-1:0]          r_cnt_p;
  logic [CW-1:0]          r_cnt_h;
  logic [WIDTH-1:0]       r_stk;

  logic                   w_s;
  logic                   w_emit;
  logic                   w_emit_stuck;
  logic                   w_set_lock;
  logic                   w_cnt_full;
  logic                   w_stk_tick;
  logic [WIDTH-1:0]       w_clamped;

  assign w_s        = r_sync[SYNC_STAGES-1];
  assign w_cnt_full = (r_cnt_p == C_STUCK);
  assign w_stk_tick = (r_stk == '1);
  assign w_clamped  = (r_cnt_h > C_SMAX) ? '1 : r_cnt_h[WIDTH-1:0];

  // Edges are registered so the FSM sees level (r_s_d) and edge pulses aligned.
  // r_vld masks the false edge produced while the reset zeros drain from the chain.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync <= '0;
      r_vld  <= '0;
      r_s_d  <= 1'b0;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_pwm_in};
      r_vld  <= {r_vld[SYNC_STAGES-1:0], 1'b1};
      r_s_d  <= w_s;
      r_rise <= w_s & ~r_s_d & r_vld[SYNC_STAGES];
      r_fall <= ~w_s & r_s_d & r_vld[SYNC_STAGES];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt_p <= '0;
      r_cnt_h <= '0;
    end else if (r_rise) begin
      r_cnt_p <= CW'(1);
      r_cnt_h <= CW'(1);
    end else begin
      r_cnt_p <= (r_cnt_p == '1) ? r_cnt_p : r_cnt_p + CW'(1);
      if (r_s_d && (r_cnt_h != '1)) begin
        r_cnt_h <= r_cnt_h + CW'(1);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_ACQUIRE;
      r_stk   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_STUCK) begin
        r_stk <= r_stk + WIDTH'(1);
      end else begin
        r_stk <= '0;
      end
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_emit       = 1'b0;
    w_emit_stuck = 1'b0;
    w_set_lock   = 1'b0;
    unique case (r_state)
      ST_ACQUIRE: begin
        if (r_rise) begin
          w_state_nxt = ST_HIGH;
        end else if (w_cnt_full) begin
          w_state_nxt  = ST_STUCK;
          w_emit_stuck = 1'b1;
        end
      end
      ST_HIGH: begin
        if (r_rise) begin
          w_emit     = 1'b1;
          w_set_lock = 1'b1;
        end else if (w_cnt_full) begin
          w_state_nxt  = ST_STUCK;
          w_emit_stuck = 1'b1;
        end else if (r_fall) begin
          w_state_nxt = ST_LOW;
        end
      end
      ST_LOW: begin
        if (r_rise) begin
          w_state_nxt = ST_HIGH;
          w_emit      = 1'b1;
          w_set_lock  = 1'b1;
        end else if (w_cnt_full) begin
          w_state_nxt  = ST_STUCK;
          w_emit_stuck = 1'b1;
        end
      end
      ST_STUCK: begin
        if (r_rise) begin
          w_state_nxt = ST_HIGH;
        end else if (w_stk_tick) begin
          w_emit_stuck = 1'b1;
        end
      end
      default: w_state_nxt = ST_ACQUIRE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_sample       <= '0;
      o_sample_valid <= 1'b0;
      o_period       <= '0;
      o_period_err   <= 1'b0;
      o_locked       <= 1'b0;
    end else begin
      o_sample_valid <= w_emit | w_emit_stuck;
      if (w_emit) begin
        o_sample     <= w_clamped;
        o_period     <= r_cnt_p;
        o_period_err <= (r_cnt_p != C_NOMINAL);
      end else if (w_emit_stuck) begin
        o_sample     <= {WIDTH{r_s_d}};
        o_period     <= C_NOMINAL;
        o_period_err <= 1'b0;
      end
      o_locked <= w_set_lock |
                  (o_locked & ((w_state_nxt == ST_HIGH) || (w_state_nxt == ST_LOW)));
    end
  end

endmodule

// File: tb/tb_pwm_sample_decoder.sv
// Drives PWM waveforms into two decoders (2 and 3 sync stages) and checks
// every cycle against an input-time reference model of the decoding rules.
module tb_pwm_sample_decoder;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pwm = 1'b0;

  always #5 clk = ~clk;

  logic [W-1:0] smp2, smp3;
  logic         vld2, vld3;
  logic [W+1:0] per2, per3;
  logic         err2, err3;
  logic         lck2, lck3;

  pwm_sample_decoder #(.WIDTH(W), .SYNC_STAGES(2)) u_dut2 (
    .i_clk(clk), .i_rst(rst), .i_pwm_in(pwm),
    .o_sample(smp2), .o_sample_valid(vld2), .o_period(per2),
    .o_period_err(err2), .o_locked(lck2)
  );

  pwm_sample_decoder #(.WIDTH(W), .SYNC_STAGES(3)) u_dut3 (
    .i_clk(clk), .i_rst(rst), .i_pwm_in(pwm),
    .o_sample(smp3), .o_sample_valid(vld3), .o_period(per3),
    .o_period_err(err3), .o_locked(lck3)
  );

  typedef struct {
    int tin;
    int smp;
    int per;
    bit err;
    bit lck;
  } ev_t;

  ev_t evs[$];
  int  rd[2];
  int  lat[2] = '{4, 5};
  int  exp_s[2], exp_p[2];
  bit  exp_e[2], exp_l[2];

  int  total = 0;
  int  bad   = 0;
  int  cyc   = 0;

  int  last_rise = -1;
  int  hcnt = 0;
  int  stuck_next = 0;
  bit  armed = 0, stuck = 0, prev_pwm = 0, mask_rise = 0, rst_pending = 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
    end
  endtask

  task automatic push(input int t, input int s, input int p, input bit e, input bit l);
    ev_t ev;
    ev.tin = t; ev.smp = s; ev.per = p; ev.err = e; ev.lck = l;
    evs.push_back(ev);
  endtask

  task automatic check_inst(input int k, input logic v, input logic [W-1:0] s,
                            input logic [W+1:0] p, input logic e, input logic l);
    bit hit;
    string nm;
    hit = 0;
    nm = (k == 0) ? "sync2" : "sync3";
    if (rd[k] < evs.size()) begin
      if (evs[rd[k]].tin + lat[k] == cyc) begin
        hit      = 1;
        exp_s[k] = evs[rd[k]].smp;
        exp_p[k] = evs[rd[k]].per;
        exp_e[k] = evs[rd[k]].err;
        exp_l[k] = evs[rd[k]].lck;
        rd[k]++;
      end
    end
    chk({nm, "_valid"},  32'(v), 32'(hit));
    chk({nm, "_sample"}, 32'(s), 32'(exp_s[k]));
    chk({nm, "_period"}, 32'(p), 32'(exp_p[k]));
    chk({nm, "_err"},    32'(e), 32'(exp_e[k]));
    chk({nm, "_locked"}, 32'(l), 32'(exp_l[k]));
  endtask

  // One clock: drive pwm/rst after the edge, advance the model, check at negedge.
  task automatic step(input bit v, input bit r);
    bit rise;
    @(posedge clk);
    #1;
    cyc++;
    if (rst_pending) begin
      for (int k = 0; k < 2; k++) begin
        rd[k] = evs.size();
        exp_s[k] = 0; exp_p[k] = 0; exp_e[k] = 0; exp_l[k] = 0;
      end
      armed = 0; stuck = 0; last_rise = -1; hcnt = 0; mask_rise = 1;
    end
    pwm = v;
    rst = r;
    rst_pending = r;
    if (!r) begin
      rise = v && !prev_pwm && !mask_rise;
      if (rise) begin
        if (armed)
          push(cyc, (hcnt > 255) ? 255 : hcnt, cyc - last_rise, (cyc - last_rise) != 256, 1'b1);
        armed = 1; stuck = 0; last_rise = cyc; hcnt = 0;
      end else if (!stuck && last_rise >= 0 && (cyc - last_rise) == 512) begin
        stuck = 1; armed = 0; stuck_next = cyc + 256;
        push(cyc, v ? 255 : 0, 256, 1'b0, 1'b0);
      end else if (stuck && cyc == stuck_next) begin
        stuck_next += 256;
        push(cyc, v ? 255 : 0, 256, 1'b0, 1'b0);
      end
      if (v) hcnt++;
      prev_pwm  = v;
      mask_rise = 0;
    end
    @(negedge clk);
    check_inst(0, vld2, smp2, per2, err2, lck2);
    check_inst(1, vld3, smp3, per3, err3, lck3);
  endtask

  task automatic period(input int h, input int p);
    repeat (h) step(1'b1, 1'b0);
    repeat (p - h) step(1'b0, 1'b0);
  endtask

  initial begin
    int p, h;
    rd[0] = 0; rd[1] = 0;
    for (int k = 0; k < 2; k++) begin
      exp_s[k] = 0; exp_p[k] = 0; exp_e[k] = 0; exp_l[k] = 0;
    end

    repeat (3) step(1'b0, 1'b1);
    repeat (10) step(1'b0, 1'b0);

    repeat (4) period(100, 256);
    repeat (3) period(255, 256);
    repeat (3) period(1, 256);

    period(100, 256);
    repeat (1000) step(1'b0, 1'b0);
    repeat (3) period(100, 256);
    period(100, 256);
    repeat (1000) step(1'b1, 1'b0);
    repeat (100) step(1'b0, 1'b0);
    repeat (3) period(100, 256);

    repeat (3) period(150, 300);
    repeat (3) period(50, 200);
    repeat (2) period(300, 400);

    for (int i = 0; i < 20; i++) begin
      p = $urandom_range(400, 150);
      h = $urandom_range(p - 1, 1);
      period(h, p);
    end

    repeat (2) period(100, 256);
    repeat (50) step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    repeat (49) step(1'b1, 1'b0);
    repeat (156) step(1'b0, 1'b0);
    repeat (3) period(100, 256);
    repeat (20) step(1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
